keypad_entry_display: RTL and testbench
=======================================

# keypad_entry_display

Parametrised keypad entry buffer and multi-digit seven-segment scan controller. Sits between the keypad decoder (4-bit code plus press pulse) and the board's seven-segment pins. It keeps an N-digit shift-entry buffer with clear and backspace, and time-multiplexes the buffer onto one shared segment bus with one-hot digit selects. This replaces fixed two-digit toggle handling with a configurable digit count, refresh rate, overflow policy and anti-ghost blanking.

## Interface

- NUM_DIGITS, 2: digits in the buffer and on the display; legal range 2..8.
- CLK_FREQ, 125_000_000: clk frequency in Hz.
- REFRESH_HZ, 1000: full-frame refresh rate in Hz.
- WRAP, 1: when full, 1 = discard the oldest digit on a new key; 0 = ignore the new key.
- GHOST_BLANK, 4: clk cycles that seg is forced to 0 at the start of each digit slot.
- clk in 1: single clock; everything is rising-edge.
- rst in 1: synchronous, active-high reset.
- key_valid in 1: single-cycle pulse; key_code is valid in that cycle.
- key_code in 4: hex value 0x0..0xF.
- clear in 1: single-cycle pulse; empties the buffer.
- backspace in 1: single-cycle pulse; removes the newest digit.
- digits out 4*NUM_DIGITS: buffer contents; digits[3:0] is digit 0 (rightmost, newest).
- count out $clog2(NUM_DIGITS+1): number of entered digits.
- full out 1: high when count == NUM_DIGITS.
- overflow out 1: one-cycle pulse when key_valid arrives while full.
- seg out 7: segments {g,f,e,d,c,b,a}, active-high.
- dig_sel out NUM_DIGITS: one-hot digit select. On the two-digit board, chip_sel = dig_sel[1].

## Operation

- Entry buffer: NUM_DIGITS 4-bit registers plus count.
- Event priority within one cycle: rst > clear > key_valid > backspace. Only the highest-priority event takes effect.
- key_valid, not full:
  - Shift all digits up one position; digit 0 <= key_code.
  - count increments.
- key_valid, full, WRAP=1: same shift; the top digit is lost; count stays NUM_DIGITS; overflow pulses.
- key_valid, full, WRAP=0: buffer and count unchanged; overflow pulses.
- backspace, count > 0: shift all digits down one position; the top digit <= 0; count decrements.
- backspace, count == 0: no-op.
- clear: all digits <= 0, count <= 0.
- Scan counter:
  - Prescaler counts 0..TICK_DIV-1, where TICK_DIV = CLK_FREQ/(REFRESH_HZ*NUM_DIGITS).
  - On terminal count, slot index advances by one, wrapping from NUM_DIGITS-1 to 0.
- Slot FSM states:
  - BLANK: GHOST_BLANK cycles; seg = 0, dig_sel = new slot.
  - SHOW: remaining cycles; seg = decode(digit[slot]).
  - If GHOST_BLANK = 0, BLANK is skipped.
  - Elaboration asserts TICK_DIV > GHOST_BLANK.
- Hex decode: 0->0111111, 1->0000110, 2->1011011, 3->1001111, 4->1100110, 5->1101101, 6->1111101, 7->0000111, 8->1111111, 9->1101111, A->1110111, b->1111100, C->0111001, d->1011110, E->1111001, F->1110001.

## Timing

- Reset values: digits 0, count 0, full 0, overflow 0, prescaler 0, slot 0, dig_sel = 1 (one-hot digit 0), seg = 0, FSM = BLANK.
- Buffer latency: an event at cycle n updates digits, count, full and overflow at n+1. All four are registered.
- seg and dig_sel are registered and change together. The slot change is visible the cycle after prescaler terminal count.
- Display latency: a buffer change appears on seg by n+2 if that digit is in SHOW; otherwise on its next SHOW.
- clear, key and backspace events do not disturb the prescaler, slot or FSM.
- Reset asserted mid-slot returns the scan to slot 0, BLANK, on the next edge.
- Back-to-back key_valid pulses on consecutive cycles are each accepted.

## Configuration

- Macro KEYPAD_ENTRY_BLANK_LEADING_EN.
- Defined: digit positions >= count show seg = 0 (blank), so an empty buffer shows a dark display.
- Undefined: every position is decoded, so unentered positions show "0" (0111111).
- Only seg is affected; digits, count and dig_sel are identical in both builds.

## Test plan

- Reset, NUM_DIGITS=4, CLK_FREQ=1000, REFRESH_HZ=125, GHOST_BLANK=1 (TICK_DIV=2) -> dig_sel sequence 0001, 0010, 0100, 1000, 0001, ..., two cycles per slot, seg = 0 in the first cycle of each slot.
- Keys 1, 2, 3 -> digits = 0x0123, count = 3. Check the build with the macro defined: slot 3 seg = 0. Check the build without it: slot 3 seg = 0111111.
- WRAP=1, keys 1..5 -> digits = 0x2345, count = 4, full = 1, overflow pulses once, on key 5. WRAP=0, same keys -> digits = 0x1234, overflow pulses once.
- Backspace after 0x0123 -> 0x0012, count = 2. Backspace on an empty buffer -> unchanged, no overflow.
- key_valid and clear in the same cycle -> buffer 0, count 0. key_valid and backspace in the same cycle -> the key wins.
- rst pulse mid-slot with count = 3 -> next cycle all outputs at reset values, dig_sel = 0001.

Source files
------------

// File: rtl/keypad_entry_display.sv
// Keypad entry buffer (shift-in, clear, backspace) with multiplexed seven-segment scan.
// Optional macro KEYPAD_ENTRY_BLANK_LEADING_EN blanks digit positions that have not been entered.
`timescale 1ns/1ps

module keypad_entry_display #(
   parameter int unsigned NUM_DIGITS  = 2,
   parameter int unsigned CLK_FREQ    = 125_000_000,
   parameter int unsigned REFRESH_HZ  = 1000,
   parameter int unsigned WRAP        = 1,
   parameter int unsigned GHOST_BLANK = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              key_valid,
   input  logic [3:0]                        key_code,
   input  logic                              clear,
   input  logic                              backspace,
   output logic [4*NUM_DIGITS-1:0]           digits,
   output logic [$clog2(NUM_DIGITS+1)-1:0]   count,
   output logic                              full,
   output logic                              overflow,
   output logic [6:0]                        seg,
   output logic [NUM_DIGITS-1:0]             dig_sel
);

   localparam int unsigned CW       = $clog2(NUM_DIGITS + 1);
   localparam int unsigned SW       = $clog2(NUM_DIGITS);
   localparam int unsigned TICK_DIV = CLK_FREQ / (REFRESH_HZ * NUM_DIGITS);
   localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   // Parameter sanity checks at elaboration
   if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("keypad_entry_display: NUM_DIGITS must be 2..8");
   end
   if (TICK_DIV <= GHOST_BLANK) begin : g_bad_blank
      $error("keypad_entry_display: TICK_DIV must exceed GHOST_BLANK");
   end

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } state_t;

   logic [NUM_DIGITS-1:0][3:0] buf_q, buf_n;
   logic [CW-1:0]              count_q, count_n;
   logic                       full_q, full_n;
   logic                       ovf_q, ovf_n;
   logic [PW-1:0]              pre_q, pre_n;
   logic [SW-1:0]              slot_q, slot_n;
   state_t                     state_q, state_n;
   logic [6:0]                 seg_q, seg_n;
   logic [NUM_DIGITS-1:0]      sel_q, sel_n;
   logic                       tick;

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'b0111111;
         4'h1:    s = 7'b0000110;
         4'h2:    s = 7'b1011011;
         4'h3:    s = 7'b1001111;
         4'h4:    s = 7'b1100110;
         4'h5:    s = 7'b1101101;
         4'h6:    s = 7'b1111101;
         4'h7:    s = 7'b0000111;
         4'h8:    s = 7'b1111111;
         4'h9:    s = 7'b1101111;
         4'hA:    s = 7'b1110111;
         4'hB:    s = 7'b1111100;
         4'hC:    s = 7'b0111001;
         4'hD:    s = 7'b1011110;
         4'hE:    s = 7'b1111001;
         default: s = 7'b1110001;
      endcase
      return s;
   endfunction

   // State register for buffer, scan counters, slot FSM and display outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         buf_q   <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
         pre_q   <= '0;
         slot_q  <= '0;
         state_q <= BLANK;
         seg_q   <= '0;
         sel_q   <= NUM_DIGITS'(1);
      end else begin
         buf_q   <= buf_n;
         count_q <= count_n;
         full_q  <= full_n;
         ovf_q   <= ovf_n;
         pre_q   <= pre_n;
         slot_q  <= slot_n;
         state_q <= state_n;
         seg_q   <= seg_n;
         sel_q   <= sel_n;
      end
   end

   // Entry buffer: clear beats key, key beats backspace
   always_comb begin
      buf_n   = buf_q;
      count_n = count_q;
      ovf_n   = 1'b0;
      if (clear) begin
         buf_n   = '0;
         count_n = '0;
      end else if (key_valid) begin
         if (!full_q) begin
            buf_n   = {buf_q[NUM_DIGITS-2:0], key_code};
            count_n = count_q + CW'(1);
         end else begin
            ovf_n = 1'b1;
            if (WRAP != 0) begin
               buf_n = {buf_q[NUM_DIGITS-2:0], key_code};
            end
         end
      end else if (backspace && (count_q != '0)) begin
         buf_n   = {4'h0, buf_q[NUM_DIGITS-1:1]};
         count_n = count_q - CW'(1);
      end
      full_n = (count_n == CW'(NUM_DIGITS));
   end

   // Scan: prescaler, slot index, BLANK/SHOW FSM and registered seg/dig_sel
   always_comb begin
      tick    = (pre_q == PW'(TICK_DIV - 1));
      pre_n   = tick ? '0 : pre_q + PW'(1);
      slot_n  = slot_q;
      state_n = state_q;
      seg_n   = '0;
      sel_n   = sel_q;

      if (tick) begin
         slot_n = (slot_q == SW'(NUM_DIGITS - 1)) ? '0 : slot_q + SW'(1);
      end

      case (state_q)
         BLANK: if (32'(pre_n) >= GHOST_BLANK) state_n = SHOW;
         SHOW:  if (tick && (GHOST_BLANK != 0)) state_n = BLANK;
         default: state_n = BLANK;
      endcase

      sel_n = NUM_DIGITS'(1) << slot_n;

      // Decode from the registered buffer so a change lands on seg two cycles after the event
      if (state_n == SHOW) begin
         seg_n = hex7(buf_q[slot_n]);
`ifdef KEYPAD_ENTRY_BLANK_LEADING_EN
         if (32'(slot_n) >= 32'(count_q)) seg_n = '0;
`endif
      end
   end

   assign digits   = buf_q;
   assign count    = count_q;
   assign full     = full_q;
   assign overflow = ovf_q;
   assign seg      = seg_q;
   assign dig_sel  = sel_q;

endmodule

// File: tb/tb_keypad_entry_display.sv
// Directed bench for keypad_entry_display: table of buffer events plus scan/reset sequences.
`timescale 1ns/1ps

module tb_keypad_entry_display;

   localparam int unsigned N = 4;

   logic        clk = 1'b0;
   logic        rst, key_valid, clear, backspace;
   logic [3:0]  key_code;

   logic [15:0] digits_w, digits_nw;
   logic [2:0]  count_w, count_nw;
   logic        full_w, full_nw, ovf_w, ovf_nw;
   logic [6:0]  seg_w, seg_nw;
   logic [3:0]  sel_w, sel_nw;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   keypad_entry_display #(.NUM_DIGITS(N), .CLK_FREQ(1000), .REFRESH_HZ(125), .WRAP(1), .GHOST_BLANK(1)) dut (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .clear(clear),
      .backspace(backspace), .digits(digits_w), .count(count_w), .full(full_w),
      .overflow(ovf_w), .seg(seg_w), .dig_sel(sel_w));

   keypad_entry_display #(.NUM_DIGITS(N), .CLK_FREQ(1000), .REFRESH_HZ(125), .WRAP(0), .GHOST_BLANK(1)) dut_nw (
      .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .clear(clear),
      .backspace(backspace), .digits(digits_nw), .count(count_nw), .full(full_nw),
      .overflow(ovf_nw), .seg(seg_nw), .dig_sel(sel_nw));

   typedef struct {
      logic        r, kv;
      logic [3:0]  kc;
      logic        clr, bs;
      logic [15:0] d_w;
      int          cnt;
      logic        f, o_w;
      logic [15:0] d_nw;
      logic        o_nw;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] ref_seg(input int slot, input logic [15:0] d, input int cnt);
      logic [3:0] v;
      v = d[slot*4 +: 4];
`ifdef KEYPAD_ENTRY_BLANK_LEADING_EN
      if (slot >= cnt) return 7'b0000000;
`else
      if (cnt < 0) return 7'b0000000;
`endif
      case (v)
         4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
         4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
         4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
         4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
         4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
         4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
         4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
         4'hE: return 7'b1111001;  default: return 7'b1110001;
      endcase
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rst = 1'b0; key_valid = 1'b0; key_code = 4'h0; clear = 1'b0; backspace = 1'b0;
   endtask

   initial begin
      bit found;
      idle_inputs();
      //         rst   kv    kc     clr   bs    d_w       cnt f     o_w   d_nw      o_nw
      vecs[0]  = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 16'h0000, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 16'h0001, 1, 1'b0, 1'b0, 16'h0001, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 16'h0012, 2, 1'b0, 1'b0, 16'h0012, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 16'h0123, 3, 1'b0, 1'b0, 16'h0123, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 16'h0012, 2, 1'b0, 1'b0, 16'h0012, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 16'h0123, 3, 1'b0, 1'b0, 16'h0123, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 4'h4, 1'b0, 1'b0, 16'h1234, 4, 1'b1, 1'b0, 16'h1234, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 16'h2345, 4, 1'b1, 1'b1, 16'h1234, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h2345, 4, 1'b1, 1'b0, 16'h1234, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 4'h6, 1'b0, 1'b1, 16'h3456, 4, 1'b1, 1'b1, 16'h1234, 1'b1};
      vecs[10] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 16'h0345, 3, 1'b0, 1'b0, 16'h0123, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 16'h0000, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 16'h0000, 0, 1'b0, 1'b0, 16'h0000, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 4'h7, 1'b1, 1'b0, 16'h0000, 0, 1'b0, 1'b0, 16'h0000, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 4'h9, 1'b0, 1'b1, 16'h0009, 1, 1'b0, 1'b0, 16'h0009, 1'b0};
      vecs[15] = '{1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 16'h009A, 2, 1'b0, 1'b0, 16'h009A, 1'b0};

      for (int i = 0; i < 16; i++) begin
         rst = vecs[i].r; key_valid = vecs[i].kv; key_code = vecs[i].kc;
         clear = vecs[i].clr; backspace = vecs[i].bs;
         cycle();
         idle_inputs();
         chk($sformatf("v%0d digits", i),    32'(digits_w),  32'(vecs[i].d_w));
         chk($sformatf("v%0d count", i),     32'(count_w),   32'(vecs[i].cnt));
         chk($sformatf("v%0d full", i),      32'(full_w),    32'(vecs[i].f));
         chk($sformatf("v%0d overflow", i),  32'(ovf_w),     32'(vecs[i].o_w));
         chk($sformatf("v%0d digits_nw", i), 32'(digits_nw), 32'(vecs[i].d_nw));
         chk($sformatf("v%0d count_nw", i),  32'(count_nw),  32'(vecs[i].cnt));
         chk($sformatf("v%0d full_nw", i),   32'(full_nw),   32'(vecs[i].f));
         chk($sformatf("v%0d ovf_nw", i),    32'(ovf_nw),    32'(vecs[i].o_nw));
      end

      // Scan sequence from reset: two cycles per slot, first one blanked
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         int slot;
         slot = (k / 2) % 4;
         chk($sformatf("scan%0d dig_sel", k), 32'(sel_w), 32'(1 << slot));
         chk($sformatf("scan%0d dig_sel_nw", k), 32'(sel_nw), 32'(1 << slot));
         chk($sformatf("scan%0d seg", k), 32'(seg_w),
             (k % 2 == 0) ? 32'(0) : 32'(ref_seg(slot, 16'h0000, 0)));
         chk($sformatf("scan%0d seg_nw", k), 32'(seg_nw),
             (k % 2 == 0) ? 32'(0) : 32'(ref_seg(slot, 16'h0000, 0)));
         cycle();
      end

      // Back-to-back keys, then a full frame showing 0x0123
      key_valid = 1'b1;
      key_code = 4'h1; cycle();
      key_code = 4'h2; cycle();
      key_code = 4'h3; cycle();
      idle_inputs();
      chk("keys123 digits", 32'(digits_w), 32'h0123);
      chk("keys123 count", 32'(count_w), 32'd3);
      cycle(); cycle(); cycle();
      found = 1'b0;
      for (int t = 0; t < 20 && !found; t++) begin
         if (sel_w == 4'b0001 && seg_w == 7'b0) found = 1'b1;
         else cycle();
      end
      chk("sync slot0 blank", 32'(found), 32'd1);
      for (int k = 0; k < 8; k++) begin
         int slot;
         slot = k / 2;
         chk($sformatf("frame%0d dig_sel", k), 32'(sel_w), 32'(1 << slot));
         chk($sformatf("frame%0d seg", k), 32'(seg_w),
             (k % 2 == 0) ? 32'(0) : 32'(ref_seg(slot, 16'h0123, 3)));
         cycle();
      end

      // Reset in the middle of slot 2 with three digits entered
      found = 1'b0;
      for (int t = 0; t < 20 && !found; t++) begin
         if (sel_w == 4'b0100) found = 1'b1;
         else cycle();
      end
      chk("sync slot2", 32'(found), 32'd1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("rst digits", 32'(digits_w), 32'h0);
      chk("rst count", 32'(count_w), 32'd0);
      chk("rst full", 32'(full_w), 32'd0);
      chk("rst overflow", 32'(ovf_w), 32'd0);
      chk("rst seg", 32'(seg_w), 32'd0);
      chk("rst dig_sel", 32'(sel_w), 32'b0001);
      cycle();
      chk("post-rst dig_sel", 32'(sel_w), 32'b0001);
      chk("post-rst seg", 32'(seg_w), 32'(ref_seg(0, 16'h0000, 0)));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
